// File: rtl/waveform_ctrl_pkg.sv
// Shared types and the mode-to-select decode for the waveform mode controller.
package waveform_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_SAW      = 2'd0,
      MODE_REF_PWM  = 2'd1,
      MODE_REF_R2R  = 2'd2,
      MODE_REF_BOTH = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_BLANK = 2'd1,
      S_RUN   = 2'd2
   } ctrl_state_t;

   // Select word layout: {fourth, third, second, first, r2r_scaled}
   function automatic logic [4:0] sel_word(input mode_t m);
      logic [4:0] w;
      case (m)
         MODE_SAW:      w = 5'b0000_0;
         MODE_REF_PWM:  w = 5'b1000_0;
         MODE_REF_R2R:  w = 5'b1001_0;
         MODE_REF_BOTH: w = 5'b1000_1;
         default:       w = 5'b0000_0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/ref_scaler.sv
// Reference capture stage followed by a saturating gain stage for the R2R byte.
module ref_scaler
   import waveform_ctrl_pkg::*;
#(
   parameter int unsigned R2R_GAIN_NUM   = 1,
   parameter int unsigned R2R_GAIN_SHIFT = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] ref_in,
   input  logic       ref_valid,
   input  logic       ref_hold,
   output logic [7:0] ref_o,
   output logic [7:0] ref_r2r_o
);

   logic [7:0]  ref_q;
   logic [7:0]  r2r_q;
   logic [7:0]  r2r_d;
   logic [11:0] prod;
   logic [11:0] shifted;

   // Scale the captured byte in 12 bits, then clamp to 8 bits.
   always_comb begin
      prod    = 12'(ref_q) * 12'(R2R_GAIN_NUM);
      shifted = prod >> R2R_GAIN_SHIFT;
      r2r_d   = (|shifted[11:8]) ? 8'hFF : shifted[7:0];
   end

   // Capture qualified samples; the scaled byte follows one clock later.
   always_ff @(posedge clk) begin
      if (reset) begin
         ref_q <= '0;
         r2r_q <= '0;
      end else begin
         if (ref_valid && !ref_hold) ref_q <= ref_in;
         r2r_q <= r2r_d;
      end
   end

   assign ref_o     = ref_q;
   assign ref_r2r_o = r2r_q;

endmodule

// File: rtl/waveform_mode_controller.sv
// Mode sequencer for the waveform generator: run/blank FSM, select decode, reference path.
module waveform_mode_controller
   import waveform_ctrl_pkg::*;
#(
   parameter int unsigned BLANK_CYCLES   = 200_000,
   parameter int unsigned R2R_GAIN_NUM   = 1,
   parameter int unsigned R2R_GAIN_SHIFT = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       mode_next,
   input  logic       mode_prev,
   input  logic [7:0] ref_in,
   input  logic       ref_valid,
   input  logic       ref_hold,
   output logic       gen_enable,
   output logic       first_select,
   output logic       second_select,
   output logic       third_select,
   output logic       fourth_select,
   output logic       r2r_binary_scaled_enable,
   output logic [7:0] current_reference,
   output logic [7:0] current_reference_r2r,
   output logic [1:0] mode,
   output logic       blanking
);

   localparam int unsigned CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(BLANK_CYCLES - 1);

   ctrl_state_t   state_q, state_d;
   mode_t         mode_q, mode_d, mode_step;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    sel_q, sel_d;
   logic          gen_q, gen_d;
   logic          blank_q, blank_d;
   logic          step;

   // Next state, mode and blank counter; outputs are decoded from the next
   // state so they register on the same edge as the mode change.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      step      = mode_next ^ mode_prev;
      mode_step = mode_next ? mode_t'(mode_q + 2'd1) : mode_t'(mode_q - 2'd1);
      case (state_q)
         S_OFF: begin
            if (step) mode_d = mode_step;
            if (run) begin
               state_d = S_BLANK;
               cnt_d   = CNT_LOAD;
            end
         end
         S_BLANK: begin
            if (!run) begin
               state_d = S_OFF;
            end else if (step) begin
               mode_d = mode_step;
               cnt_d  = CNT_LOAD;
            end else if (cnt_q == '0) begin
               state_d = S_RUN;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RUN: begin
            if (!run) begin
               state_d = S_OFF;
            end else if (step) begin
               mode_d  = mode_step;
               state_d = S_BLANK;
               cnt_d   = CNT_LOAD;
            end
         end
         default: state_d = S_OFF;
      endcase
      gen_d   = (state_d == S_RUN);
      blank_d = (state_d == S_BLANK);
      sel_d   = sel_word(mode_d);
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_OFF;
         mode_q  <= MODE_SAW;
         cnt_q   <= '0;
         sel_q   <= '0;
         gen_q   <= 1'b0;
         blank_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         gen_q   <= gen_d;
         blank_q <= blank_d;
      end
   end

   ref_scaler #(
      .R2R_GAIN_NUM   (R2R_GAIN_NUM),
      .R2R_GAIN_SHIFT (R2R_GAIN_SHIFT)
   ) u_ref_scaler (
      .clk       (clk),
      .reset     (reset),
      .ref_in    (ref_in),
      .ref_valid (ref_valid),
      .ref_hold  (ref_hold),
      .ref_o     (current_reference),
      .ref_r2r_o (current_reference_r2r)
   );

   assign gen_enable               = gen_q;
   assign blanking                 = blank_q;
   assign mode                     = mode_q;
   assign fourth_select            = sel_q[4];
   assign third_select             = sel_q[3];
   assign second_select            = sel_q[2];
   assign first_select             = sel_q[1];
   assign r2r_binary_scaled_enable = sel_q[0];

endmodule
